// File: rtl/multicycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_sequencer_pkg
//  Purpose  : Shared encodings for the multicycle control sequencer: state
//             codes, opcode constants, pc_source / fault_code / alu_op
//             enumerations and an opcode legality helper.
//  Revision : 1.0 - initial release
// ============================================================================
package multicycle_sequencer_pkg;

   // State encoding is visible on the state output, so the values are fixed.
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd7
   } state_e;

   localparam logic [7:0] OP_RTYPE = 8'h00;
   localparam logic [7:0] OP_ADDI  = 8'h08;
   localparam logic [7:0] OP_LW    = 8'h23;
   localparam logic [7:0] OP_SW    = 8'h2B;
   localparam logic [7:0] OP_BEQ   = 8'h04;
   localparam logic [7:0] OP_BLT   = 8'h05;
   localparam logic [7:0] OP_BEQI  = 8'h06;
   localparam logic [7:0] OP_J     = 8'h02;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JUMP   = 2'd2
   } pc_source_e;

   typedef enum logic [1:0] {
      FAULT_NONE    = 2'd0,
      FAULT_ILLEGAL = 2'd1,
      FAULT_STACK   = 2'd2,
      FAULT_TIMEOUT = 2'd3
   } fault_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_SUB   = 2'd1,
      ALU_FUNCT = 2'd2
   } alu_op_e;

   // Wide enough for the largest supported MEM_TIMEOUT (255).
   localparam int WAIT_CNT_W = 8;

   function automatic logic is_legal_opcode(input logic [7:0] op);
      case (op)
         OP_RTYPE, OP_ADDI, OP_LW, OP_SW,
         OP_BEQ, OP_BLT, OP_BEQI, OP_J: is_legal_opcode = 1'b1;
         default:                       is_legal_opcode = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_wait_timer
//  Purpose  : Counts unacknowledged memory-wait cycles and flags a timeout
//             on the MEM_TIMEOUT-th consecutive unacknowledged cycle. The
//             count is held at zero whenever no request is outstanding, so
//             it is always clear on entry to a wait state.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_wait_timer
   import multicycle_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)(
   input  logic system_clock,
   input  logic reset,
   input  logic wait_active,
   input  logic mem_ack,
   output logic timeout
);

   localparam logic [WAIT_CNT_W-1:0] LIMIT = 8'(MEM_TIMEOUT - 1);

   logic [WAIT_CNT_W-1:0] count_d;
   logic [WAIT_CNT_W-1:0] count_q;

   // Timeout fires in the cycle that would be the MEM_TIMEOUT-th miss.
   always_comb begin
      timeout = wait_active && !mem_ack && (count_q == LIMIT);
      count_d = '0;
      if (wait_active && !mem_ack && !timeout) begin
         count_d = count_q + 8'd1;
      end
   end

   // Wait-count register.
   always_ff @(posedge system_clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_sequencer
//  Purpose  : Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT)
//             with memory-wait timeout, illegal-opcode and optional stack
//             fault halting, and a retired-instruction counter.
//             mem_req is registered and cleared by reset, so the first FETCH
//             cycle after reset issues no request; mem_ack is only honoured
//             while a request is outstanding.
//  Config   : STACK_FAULT_HALT_EN - when defined, a stack guard error during
//             EXEC/MEM/WB halts with fault_code=2.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)(
   input  logic        system_clock,
   input  logic        reset,
   input  logic [7:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        alu_zero,
   input  logic        alu_sign,
   input  logic        stack_overflow,
   input  logic        stack_underflow,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic [1:0]  pc_source,
   output logic        reg_dest,
   output logic        alu_src,
   output logic        mem_to_reg,
   output logic [1:0]  alu_op,
   output logic [2:0]  state,
   output logic        halted,
   output logic [1:0]  fault_code,
   output logic [15:0] instr_count
);

   state_e        state_d, state_q;
   fault_e        fault_d, fault_q;
   logic [15:0]   instr_count_d, instr_count_q;
   logic          mem_req_d, mem_req_q;
   logic          w_timeout;
   logic          w_wait_active;
   logic          w_stack_fault;
   logic          w_retire;

   // The ALU decodes funct itself; this block only routes alu_op=2.
   logic unused_funct;
   assign unused_funct = ^funct;

`ifdef STACK_FAULT_HALT_EN
   assign w_stack_fault = (stack_overflow || stack_underflow) &&
                          ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB));
`else
   logic unused_stack;
   assign unused_stack  = stack_overflow | stack_underflow;
   assign w_stack_fault = 1'b0;
`endif

   assign w_wait_active = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && mem_req_q;

   multicycle_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .system_clock (system_clock),
      .reset        (reset),
      .wait_active  (w_wait_active),
      .mem_ack      (mem_ack),
      .timeout      (w_timeout)
   );

   // Next-state, fault capture, retirement and per-state datapath controls.
   always_comb begin
      state_d       = state_q;
      fault_d       = fault_q;
      instr_count_d = instr_count_q;
      w_retire      = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      mem_we        = 1'b0;
      pc_source     = PC_SEQ;
      reg_dest      = 1'b0;
      alu_src       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_op        = ALU_ADD;

      case (state_q)
         ST_FETCH: begin
            if (mem_req_q) begin
               if (w_timeout) begin
                  state_d = ST_HALT;
                  fault_d = FAULT_TIMEOUT;
               end else if (mem_ack) begin
                  ir_write  = 1'b1;
                  pc_write  = 1'b1;
                  pc_source = PC_SEQ;
                  state_d   = ST_DECODE;
               end
            end
         end
         ST_DECODE: begin
            if (is_legal_opcode(opcode)) begin
               state_d = ST_EXEC;
            end else begin
               state_d = ST_HALT;
               fault_d = FAULT_ILLEGAL;
            end
         end
         ST_EXEC: begin
            if (w_stack_fault) begin
               state_d = ST_HALT;
               fault_d = FAULT_STACK;
            end else begin
               case (opcode)
                  OP_RTYPE: begin
                     alu_op  = ALU_FUNCT;
                     state_d = ST_WB;
                  end
                  OP_ADDI: begin
                     alu_src = 1'b1;
                     state_d = ST_WB;
                  end
                  OP_LW, OP_SW: begin
                     alu_src = 1'b1;
                     state_d = ST_MEM;
                  end
                  OP_BEQ, OP_BLT, OP_BEQI: begin
                     alu_op   = ALU_SUB;
                     alu_src  = (opcode == OP_BEQI);
                     if ((((opcode == OP_BEQ) || (opcode == OP_BEQI)) && alu_zero) ||
                         ((opcode == OP_BLT) && alu_sign)) begin
                        pc_write  = 1'b1;
                        pc_source = PC_BRANCH;
                     end
                     w_retire = 1'b1;
                     state_d  = ST_FETCH;
                  end
                  OP_J: begin
                     pc_write  = 1'b1;
                     pc_source = PC_JUMP;
                     w_retire  = 1'b1;
                     state_d   = ST_FETCH;
                  end
                  default: begin
                     // Opcode changed after DECODE: treat as illegal.
                     state_d = ST_HALT;
                     fault_d = FAULT_ILLEGAL;
                  end
               endcase
            end
         end
         ST_MEM: begin
            if (w_stack_fault) begin
               state_d = ST_HALT;
               fault_d = FAULT_STACK;
            end else if (w_timeout) begin
               state_d = ST_HALT;
               fault_d = FAULT_TIMEOUT;
            end else begin
               mem_we = (opcode == OP_SW);
               if (mem_ack) begin
                  if (opcode == OP_SW) begin
                     w_retire = 1'b1;
                     state_d  = ST_FETCH;
                  end else begin
                     state_d  = ST_WB;
                  end
               end
            end
         end
         ST_WB: begin
            if (w_stack_fault) begin
               state_d = ST_HALT;
               fault_d = FAULT_STACK;
            end else begin
               reg_write  = 1'b1;
               reg_dest   = (opcode == OP_RTYPE);
               mem_to_reg = (opcode == OP_LW);
               w_retire   = 1'b1;
               state_d    = ST_FETCH;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase

      if (w_retire) begin
         instr_count_d = instr_count_q + 16'd1;
      end

      // Request tracks the state being entered, so it is aligned with state_q.
      mem_req_d = (state_d == ST_FETCH) || (state_d == ST_MEM);
   end

   // State, fault, counter and request registers.
   always_ff @(posedge system_clock) begin
      if (reset) begin
         state_q       <= ST_FETCH;
         fault_q       <= FAULT_NONE;
         instr_count_q <= 16'd0;
         mem_req_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         fault_q       <= fault_d;
         instr_count_q <= instr_count_d;
         mem_req_q     <= mem_req_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign state       = state_q;
   assign halted      = (state_q == ST_HALT);
   assign fault_code  = fault_q;
   assign instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, max cycles waiting on mem_ack before fault (range 1..255).
REQ-002 system_clock  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high; sampled on posedge system_clock.
REQ-004 opcode  in  8  instruction bits [31:24] from instruction register.
REQ-005 funct  in  6  instruction bits [5:0].
REQ-006 alu_zero / alu_sign  in  1 each  ALU zero flag, ALU result bit 31.
REQ-007 stack_overflow / stack_underflow  in  1 each  stack guard error signals.
REQ-008 mem_ack  in  1  memory completes current request.
REQ-009 mem_req / mem_we  out  1 each  memory request, write qualifier.
REQ-010 ir_write / pc_write / reg_write  out  1 each  single-cycle strobes.
REQ-011 pc_source  out  2  0=pc+4, 1=branch target, 2=jump address.
REQ-012 reg_dest / alu_src / mem_to_reg  out  1 each  datapath mux selects.
REQ-013 alu_op  out  2  0=add, 1=sub, 2=funct-decoded.
REQ-014 state  out  3  current state encoding.
REQ-015 halted  out  1  high in HALT.
REQ-016 fault_code  out  2  0=none, 1=illegal opcode, 2=stack fault, 3=memory timeout.
REQ-017 instr_count  out  16  retired-instruction count.

Function
REQ-018 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7; one state per cycle except waits.
REQ-019 FETCH SHALL hold mem_req=1, mem_we=0 until mem_ack=1, then pulse ir_write and pc_write with pc_source=0 in that same cycle and go to DECODE.
REQ-020 DECODE SHALL go to EXEC for legal opcodes, otherwise to HALT with fault_code=1.
REQ-021 Opcodes: RTYPE=8'h00, ADDI=8'h08, LW=8'h23, SW=8'h2B, BEQ=8'h04, BLT=8'h05, BEQI=8'h06, J=8'h02.
REQ-022 EXEC: RTYPE alu_op=2, ADDI/LW/SW alu_op=0 alu_src=1, BEQ/BLT/BEQI alu_op=1 (BEQI alu_src=1).
REQ-023 Branch in EXEC: pc_write=1, pc_source=1 iff (BEQ|BEQI)&alu_zero or BLT&alu_sign; then FETCH; instruction retires.
REQ-024 J in EXEC: pc_write=1, pc_source=2, then FETCH.
REQ-025 EXEC next state: LW/SW -> MEM; RTYPE/ADDI -> WB.
REQ-026 MEM SHALL hold mem_req=1 (mem_we=1 for SW) until mem_ack; LW -> WB, SW -> FETCH.
REQ-027 WB: reg_write=1 for one cycle; reg_dest=1 for RTYPE, mem_to_reg=1 for LW; then FETCH.
REQ-028 Latencies with mem_ack immediate: branch/J 3 cycles, RTYPE/ADDI/SW 4, LW 5.
REQ-029 Wait counter SHALL clear on entering FETCH/MEM, increment per unacknowledged cycle; reaching MEM_TIMEOUT -> HALT, fault_code=3, no strobes that cycle.
REQ-030 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-031 instr_count SHALL increment once per retirement (WB exit, SW MEM exit, branch/J EXEC exit), wrapping 16'hFFFF -> 0.
REQ-032 HALT SHALL assert halted, deassert all strobes and mem_req, and persist until reset.
REQ-033 All strobes SHALL be zero in states not listed as driving them.

Reset
REQ-034 reset SHALL force state=FETCH, fault_code=0, instr_count=0, wait counter=0, all strobes/selects=0, halted=0 on the next edge, overriding any state including mid-wait and HALT.
REQ-035 A pending memory request is abandoned on reset; mem_req low the cycle after.

Configuration
REQ-036 Macro STACK_FAULT_HALT_EN: defined -> stack_overflow|stack_underflow during EXEC, MEM or WB suppresses reg_write/mem_we that cycle and goes to HALT with fault_code=2.
REQ-037 Undefined -> stack signals ignored by this block; fault_code never 2.

Structure
REQ-038 Shared package SHALL hold state encoding, opcode constants, pc_source and fault_code enumerations.
REQ-039 One sub-module, multicycle_wait_timer, SHALL implement the wait counter and timeout flag.

Verification
REQ-040 ADDI, mem_ack tied high -> states 0,1,2,4; reg_write one cycle in WB; instr_count 0->1.
REQ-041 LW, mem_ack delayed 3 cycles in MEM -> 8 cycles total, mem_to_reg=1 in WB.
REQ-042 BLT with alu_sign=1 -> pc_write, pc_source=1 in EXEC; alu_sign=0 -> no pc_write in EXEC.
REQ-043 opcode 8'hFF -> HALT after DECODE, fault_code=1, halted=1 until reset.
REQ-044 mem_ack held low in FETCH with MEM_TIMEOUT=15 -> HALT after 15 cycles, fault_code=3.
REQ-045 STACK_FAULT_HALT_EN defined, stack_overflow=1 in WB -> reg_write=0, HALT, fault_code=2; reset mid-MEM -> FETCH next cycle.
